// File: rtl/alu_op_dispatcher_if.sv
// alu_op_dispatcher_if: request, ALU and result bus of the ALU issue stage
// master: request source, ALU and result consumer; slave: the dispatcher
interface alu_op_dispatcher_if #(
  parameter int WIDTH = 32,
  parameter int SHW = 5,
  parameter int TAGW = 4,
  parameter int CW = 3
);
  logic in_valid;
  logic in_ready;
  logic [3:0] in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [SHW-1:0] in_shift;
  logic [TAGW-1:0] in_tag;
  logic [3:0] alu_opcode;
  logic [WIDTH-1:0] alu_input1;
  logic [WIDTH-1:0] alu_input2;
  logic [SHW-1:0] alu_shiftValue;
  logic [WIDTH-1:0] alu_result;
  logic alu_carry;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_result;
  logic out_carry;
  logic [TAGW-1:0] out_tag;
  logic out_illegal;
  logic [CW-1:0] fifo_count;
  logic [15:0] issue_count;
  modport master (
    output in_valid, in_opcode, in_a, in_b, in_shift, in_tag, alu_result, alu_carry, out_ready,
    input in_ready, alu_opcode, alu_input1, alu_input2, alu_shiftValue,
    input out_valid, out_result, out_carry, out_tag, out_illegal, fifo_count, issue_count
  );
  modport slave (
    input in_valid, in_opcode, in_a, in_b, in_shift, in_tag, alu_result, alu_carry, out_ready,
    output in_ready, alu_opcode, alu_input1, alu_input2, alu_shiftValue,
    output out_valid, out_result, out_carry, out_tag, out_illegal, fifo_count, issue_count
  );
endinterface

// File: rtl/alu_op_dispatcher.sv
// alu_op_dispatcher: request FIFO, registered ALU issue stage and registered result stage
// ports: clk, rst (async active-high), bus (slave: in_* request, alu_* ALU drive/return, out_* result, counters)
module alu_op_dispatcher #(
  parameter int WIDTH = 32,
  parameter int SHW = 5,
  parameter int DEPTH = 4,
  parameter int TAGW = 4,
  parameter int MAXOP = 12,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input logic clk,
  input logic rst,
  alu_op_dispatcher_if.slave bus
);
  typedef struct packed {
    logic [3:0] op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0] sh;
    logic [TAGW-1:0] tag;
  } req_t;
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic c;
    logic [TAGW-1:0] tag;
    logic ill;
  } res_t;
  req_t mem_q [DEPTH];
  req_t mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t s1_q, s1_d;
  logic s1_ill_q, s1_ill_d, s1_v_q, s1_v_d;
  res_t s2_q, s2_d;
  logic out_v_q, out_v_d;
  logic [15:0] iss_q, iss_d;
  logic ready, push, pop, adv2;
  always_comb begin
    ready = cnt_q != CW'(DEPTH);
    push = bus.in_valid && ready;
    adv2 = s1_v_q && (!out_v_q || bus.out_ready);
    pop = cnt_q != '0 && (!s1_v_q || adv2);
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = req_t'{op: bus.in_opcode, a: bus.in_a, b: bus.in_b, sh: bus.in_shift, tag: bus.in_tag};
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    s1_d = pop ? mem_q[rptr_q] : s1_q;
    s1_ill_d = pop ? mem_q[rptr_q].op > 4'(MAXOP) : s1_ill_q;
    s1_v_d = pop || (s1_v_q && !adv2);
    s2_d = adv2 ? res_t'{res: s1_ill_q ? '0 : bus.alu_result, c: !s1_ill_q && bus.alu_carry, tag: s1_q.tag, ill: s1_ill_q} : s2_q;
    out_v_d = adv2 || (out_v_q && !bus.out_ready);
    iss_d = iss_q + 16'(pop);
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      s1_q <= '0;
      s1_ill_q <= 1'b0;
      s1_v_q <= 1'b0;
      s2_q <= '0;
      out_v_q <= 1'b0;
      iss_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      s1_q <= s1_d;
      s1_ill_q <= s1_ill_d;
      s1_v_q <= s1_v_d;
      s2_q <= s2_d;
      out_v_q <= out_v_d;
      iss_q <= iss_d;
    end
  end
  assign bus.in_ready = ready;
  assign bus.alu_opcode = s1_q.op;
  assign bus.alu_input1 = s1_q.a;
  assign bus.alu_input2 = s1_q.b;
  assign bus.alu_shiftValue = s1_q.sh;
  assign bus.out_valid = out_v_q;
  assign bus.out_result = s2_q.res;
  assign bus.out_carry = s2_q.c;
  assign bus.out_tag = s2_q.tag;
  assign bus.out_illegal = s2_q.ill;
  assign bus.fifo_count = cnt_q;
  assign bus.issue_count = iss_q;
endmodule

// File: tb/tb_alu_op_dispatcher.sv
// tb_alu_op_dispatcher: directed vectors, corner sequences and random streaming against a queue model
module tb_alu_op_dispatcher;
  logic clk, rst;
  int n_pass = 0, n_total = 0, n_push = 0, n_out = 0;
  alu_op_dispatcher_if #(.CW(3)) bus ();
  alu_op_dispatcher dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] r;
    logic c;
    logic [3:0] tag;
    logic ill;
  } exp_t;
  typedef struct {
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] sh;
    logic [3:0] tag;
    logic [31:0] r;
    logic c;
    logic ill;
  } vec_t;
  exp_t sb [$];
  vec_t vt [10];
  function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {a < b, a - b};
      4'd2: return {1'b0, a << sh};
      4'd3: return {1'b0, a >> sh};
      4'd4: return {1'b0, 32'($signed(a) >>> sh)};
      4'd5: return {1'b0, ~(a | b)};
      4'd6: return {1'b0, a & b};
      4'd7: return {1'b0, a ^ b};
      4'd8: return {1'b0, ~a};
      4'd9: return {1'b0, a | b};
      4'd10: return {32'd0, $signed(a) < $signed(b)};
      4'd11: return {1'b0, a};
      4'd12: return {1'b0, b};
      default: return {1'b0, a} + {1'b0, b};
    endcase
  endfunction
  always_comb {bus.alu_carry, bus.alu_result} = alu_fn(bus.alu_opcode, bus.alu_input1, bus.alu_input2, bus.alu_shiftValue);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic tick();
    logic p, q, st;
    logic [37:0] hold;
    logic [32:0] r;
    exp_t e;
    p = bus.in_valid && bus.in_ready;
    q = bus.out_valid && bus.out_ready;
    st = bus.out_valid && !bus.out_ready;
    hold = {bus.out_result, bus.out_carry, bus.out_tag, bus.out_illegal};
    if (q) begin
      if (sb.size() == 0) chk("unexpected_result", 64'(1), 64'(0));
      else begin
        e = sb.pop_front();
        chk("result", 64'(hold), 64'({e.r, e.c, e.tag, e.ill}));
        n_out++;
      end
    end
    if (p) begin
      r = alu_fn(bus.in_opcode, bus.in_a, bus.in_b, bus.in_shift);
      e.ill = bus.in_opcode > 4'd12;
      e.r = e.ill ? 32'd0 : r[31:0];
      e.c = e.ill ? 1'b0 : r[32];
      e.tag = bus.in_tag;
      sb.push_back(e);
      n_push++;
    end
    @(posedge clk);
    #1;
    if (st && !rst) chk("stall_hold", 64'({bus.out_valid, bus.out_result, bus.out_carry, bus.out_tag, bus.out_illegal}), 64'({1'b1, hold}));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
  endtask
  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 60 && (sb.size() != 0 || bus.out_valid); k++) tick();
    chk("drain_empty", 64'(sb.size()), 64'(0));
  endtask
  task automatic set_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh, input logic [3:0] tag);
    bus.in_opcode = op;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_shift = sh;
    bus.in_tag = tag;
  endtask
  initial begin
    int base_push, base_out;
    vt[0] = '{4'd6, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 4'd3, 32'hF000F000, 1'b0, 1'b0};
    vt[1] = '{4'd9, 32'h1, 32'h2, 5'd0, 4'd5, 32'h3, 1'b0, 1'b0};
    vt[2] = '{4'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 4'd7, 32'h0, 1'b0, 1'b1};
    vt[3] = '{4'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 4'd1, 32'h0, 1'b1, 1'b0};
    vt[4] = '{4'd1, 32'h5, 32'h3, 5'd0, 4'd2, 32'h2, 1'b0, 1'b0};
    vt[5] = '{4'd2, 32'h1, 32'h0, 5'd31, 4'd4, 32'h80000000, 1'b0, 1'b0};
    vt[6] = '{4'd4, 32'h80000000, 32'h0, 5'd4, 4'd6, 32'hF8000000, 1'b0, 1'b0};
    vt[7] = '{4'd12, 32'h12345678, 32'hABCD, 5'd0, 4'd8, 32'hABCD, 1'b0, 1'b0};
    vt[8] = '{4'd13, 32'h1, 32'h1, 5'd0, 4'd9, 32'h0, 1'b0, 1'b1};
    vt[9] = '{4'd1, 32'h3, 32'h5, 5'd0, 4'd10, 32'hFFFFFFFE, 1'b1, 1'b0};
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_req(4'd0, 32'd0, 32'd0, 5'd0, 4'd0);
    #1;
    chk("reset_outputs", 64'({bus.out_valid, bus.out_result, bus.out_carry, bus.out_tag, bus.out_illegal, bus.fifo_count, bus.issue_count}), 64'(0));
    chk("reset_alu", 64'({bus.alu_opcode, bus.alu_shiftValue}) | 64'(bus.alu_input1) | 64'(bus.alu_input2), 64'(0));
    chk("reset_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_req(vt[i].op, vt[i].a, vt[i].b, vt[i].sh, vt[i].tag);
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("latency_early", 64'(bus.out_valid), 64'(0));
      tick();
      chk("latency_valid", 64'(bus.out_valid), 64'(1));
      chk("vec_result", 64'({bus.out_result, bus.out_carry, bus.out_tag, bus.out_illegal}), 64'({vt[i].r, vt[i].c, vt[i].tag, vt[i].ill}));
      chk("issue_count", 64'(bus.issue_count), 64'(i + 1));
      tick();
    end
    do_reset();
    base_push = n_push;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req(4'd12, 32'd0, 32'(i), 5'd0, 4'(i));
      tick();
    end
    chk("bp_accepted", 64'(n_push - base_push), 64'(6));
    chk("bp_fifo_count", 64'(bus.fifo_count), 64'(4));
    chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("bp_drain", 64'({bus.out_valid, bus.out_tag}), 64'({1'b1, 4'(i)}));
      tick();
    end
    drain();
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(4'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 4'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    chk("illegal_out", 64'({bus.out_valid, bus.out_result, bus.out_carry, bus.out_illegal}), 64'({1'b1, 32'd0, 1'b0, 1'b1}));
    drain();
    set_req(4'd9, 32'h1, 32'h2, 5'd0, 4'd11);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("legal_after_illegal", 64'({bus.out_valid, bus.out_result, bus.out_illegal}), 64'({1'b1, 32'h3, 1'b0}));
    drain();
    do_reset();
    base_push = n_push;
    base_out = n_out;
    for (int k = 0; k < 100 && n_out - base_out < 10; k++) begin
      bus.out_ready = (k % 2) == 0;
      bus.in_valid = n_push - base_push < 10;
      set_req(4'd12, $urandom, 32'(n_push - base_push), 5'($urandom), 4'(n_push - base_push));
      tick();
    end
    chk("stream_count", 64'(n_out - base_out), 64'(10));
    drain();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_req(4'd12, 32'd0, 32'(i), 5'd0, 4'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_state", 64'({bus.out_valid, bus.fifo_count, bus.issue_count, bus.in_ready}), 64'({1'b0, 3'd0, 16'd0, 1'b1}));
    chk("rst_mid_alu", 64'({bus.alu_opcode, bus.alu_shiftValue}) | 64'(bus.alu_input1) | 64'(bus.alu_input2), 64'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(4'd9, 32'h4, 32'h8, 5'd0, 4'hC);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rst_fresh_early", 64'(bus.out_valid), 64'(0));
    tick();
    chk("rst_fresh_result", 64'({bus.out_valid, bus.out_result, bus.out_tag}), 64'({1'b1, 32'hC, 4'hC}));
    drain();
    do_reset();
    base_push = n_push;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(4'd12, 32'd0, 32'(i), 5'd0, 4'(i));
      tick();
    end
    chk("full_count", 64'({bus.fifo_count, bus.in_ready}), 64'({3'd4, 1'b0}));
    set_req(4'd12, 32'd0, 32'd6, 5'd0, 4'd6);
    bus.out_ready = 1'b1;
    tick();
    chk("full_pop_no_push", 64'({bus.fifo_count, bus.in_ready}), 64'({3'd3, 1'b1}));
    bus.out_ready = 1'b0;
    tick();
    chk("full_push_next", 64'(bus.fifo_count), 64'(4));
    chk("full_accepted", 64'(n_push - base_push), 64'(7));
    drain();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bus.in_valid = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      set_req(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom), 4'($urandom));
      tick();
    end
    drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
